// File: rtl/cry_pkg.sv
// Shared types, widths and small helpers for the cry-envelope front end.
package cry_pkg;

    typedef enum logic [0:0] {
        ACCUM  = 1'b0,
        UPDATE = 1'b1
    } cry_state_t;

    localparam int         LEVEL_W = 8;
    localparam logic [6:0] MAG_MAX = 7'd127;
    localparam int         CLIP_W  = 4;

    // -128 has no positive counterpart in 8 bits, so it saturates to 127.
    function automatic logic [6:0] rectify(input logic [7:0] s);
        if (s == 8'h80) begin
            return MAG_MAX;
        end else if (s[7]) begin
            return ~s[6:0] + 7'd1;
        end else begin
            return s[6:0];
        end
    endfunction

    function automatic logic is_clip(input logic [7:0] s);
        return (s == 8'h80) || (s == 8'h7F);
    endfunction

endpackage

// File: rtl/cry_window_avg.sv
// Rectifies incoming samples and sums them over a 2**WIN_LOG2 sample window.
// window_done marks the valid sample that completes the window.
module cry_window_avg
    import cry_pkg::*;
#(
    parameter int WIN_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       clear,
    output logic [6:0] avg,
    output logic       window_done
);

    localparam int ACC_W = 7 + WIN_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [WIN_LOG2-1:0] cnt;
    logic [6:0]          mag;

    assign mag         = rectify(sample_in);
    assign window_done = sample_valid && !clear && (cnt == '1);
    assign avg         = acc[ACC_W-1 -: 7];

    // While clear is high the finished sum is being consumed; a sample arriving
    // then becomes the first member of the next window instead of being lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            if (sample_valid) begin
                acc <= ACC_W'(mag);
                cnt <= WIN_LOG2'(1);
            end else begin
                acc <= '0;
                cnt <= '0;
            end
        end else if (sample_valid) begin
            acc <= acc + ACC_W'(mag);
            cnt <= cnt + WIN_LOG2'(1);
        end
    end

endmodule

// File: rtl/cry_envelope.sv
// Loudness envelope for huilVolume: windowed average, peak-hold with linear
// decay, and a request/ready handshake that latches the newest level.
module cry_envelope
    import cry_pkg::*;
#(
    parameter int WIN_LOG2 = 4,
    parameter int DECAY    = 2,
    parameter int CLIP_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        sample_in,
    input  logic              sample_valid,
    input  logic              dsp_ctrl,
    output logic [LEVEL_W-1:0] dsp_out,
    output logic              dsp_ready,
    output logic [CLIP_W-1:0] clip_count
);

    cry_state_t         state;
    cry_state_t         state_next;
    logic [LEVEL_W-1:0] held;
    logic [LEVEL_W-1:0] held_next;
    logic [LEVEL_W-1:0] scaled;
    logic [LEVEL_W-1:0] decayed;
    logic [6:0]         avg;
    logic               window_done;
    logic               ctrl_q;
    logic               request;
    logic               clip_hit;

    cry_window_avg #(
        .WIN_LOG2(WIN_LOG2)
    ) u_window_avg (
        .clk         (clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .clear       (state == UPDATE),
        .avg         (avg),
        .window_done (window_done)
    );

    // avg is at most 127, so doubling it always fits without saturation logic.
    assign scaled   = {avg, 1'b0};
    assign decayed  = (held >= LEVEL_W'(DECAY)) ? held - LEVEL_W'(DECAY) : '0;
    assign request  = dsp_ctrl && !ctrl_q;
    assign clip_hit = sample_valid && is_clip(sample_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        held_next  = held;
        case (state)
            ACCUM: begin
                if (window_done) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                state_next = ACCUM;
                held_next  = (scaled > decayed) ? scaled : decayed;
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // A request latches held_next so an update landing in the same cycle is
    // already visible to huilVolume.
    always_ff @(posedge clk) begin
        if (reset) begin
            held       <= '0;
            ctrl_q     <= 1'b0;
            dsp_out    <= '0;
            dsp_ready  <= 1'b0;
            clip_count <= '0;
        end else begin
            held      <= held_next;
            ctrl_q    <= dsp_ctrl;
            dsp_ready <= request;
            if (request) begin
                dsp_out    <= held_next;
                clip_count <= clip_hit ? CLIP_W'(1) : '0;
            end else if (clip_hit && (clip_count != CLIP_W'(CLIP_MAX))) begin
                clip_count <= clip_count + CLIP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cry_envelope.sv
// Directed bench for cry_envelope: a table of single-window vectors followed
// by hand-written sequences for reset, decay, races and the handshake.
module tb_cry_envelope;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sample_in = 8'h00;
    logic       sample_valid = 1'b0;
    logic       dsp_ctrl = 1'b0;
    logic [7:0] dsp_out;
    logic       dsp_ready;
    logic [3:0] clip_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_level;
        logic [3:0] exp_clip;
    } vec_t;

    vec_t vecs[8];

    cry_envelope dut (
        .clk         (clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .dsp_ctrl    (dsp_ctrl),
        .dsp_out     (dsp_out),
        .dsp_ready   (dsp_ready),
        .clip_count  (clip_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] s);
        sample_in    = s;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        sample_in    = 8'h00;
    endtask

    task automatic send_window(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i % 2 == 0) ? a : b);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        dsp_ctrl     = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic request_and_check(input string name, input logic [7:0] exp_level);
        checkOutput({name, "_ready_before"}, 16'(dsp_ready), 16'd0);
        dsp_ctrl = 1'b1;
        step();
        checkOutput({name, "_out"}, 16'(dsp_out), 16'(exp_level));
        checkOutput({name, "_ready_hi"}, 16'(dsp_ready), 16'd1);
        dsp_ctrl = 1'b0;
        step();
        checkOutput({name, "_ready_lo"}, 16'(dsp_ready), 16'd0);
    endtask

    initial begin
        int pulses;

        vecs[0] = '{8'd50,  8'hCE, 8'd100, 4'd0};
        vecs[1] = '{8'h80,  8'h80, 8'd254, 4'd15};
        vecs[2] = '{8'h7F,  8'h00, 8'd126, 4'd8};
        vecs[3] = '{8'h00,  8'h00, 8'd0,   4'd0};
        vecs[4] = '{8'd3,   8'hFC, 8'd6,   4'd0};
        vecs[5] = '{8'hFF,  8'd2,  8'd2,   4'd0};
        vecs[6] = '{8'h7F,  8'h80, 8'd254, 4'd15};
        vecs[7] = '{8'd100, 8'h81, 8'd226, 4'd0};

        // Reset state and mid-window reset
        do_reset();
        checkOutput("rst_out", 16'(dsp_out), 16'd0);
        checkOutput("rst_ready", 16'(dsp_ready), 16'd0);
        checkOutput("rst_clip", 16'(clip_count), 16'd0);
        send_window(8'd64, 8'd64);
        step();
        request_and_check("pre_rst", 8'd128);
        for (int i = 0; i < 4; i++) applyStimulus(8'd64);
        applyStimulus(8'h7F);
        checkOutput("pre_rst_clip", 16'(clip_count), 16'd1);
        do_reset();
        checkOutput("midrst_out", 16'(dsp_out), 16'd0);
        checkOutput("midrst_clip", 16'(clip_count), 16'd0);
        send_window(8'd10, 8'd10);
        step();
        request_and_check("post_rst", 8'd20);

        // Table of single windows from a cleared state
        for (int v = 0; v < 8; v++) begin
            do_reset();
            send_window(vecs[v].a, vecs[v].b);
            step();
            checkOutput($sformatf("vec%0d_clip", v), 16'(clip_count), 16'(vecs[v].exp_clip));
            request_and_check($sformatf("vec%0d", v), vecs[v].exp_level);
            checkOutput($sformatf("vec%0d_clip_clr", v), 16'(clip_count), 16'd0);
        end

        // Decay: 100 -> three silent windows -> 94, then floor at 0
        do_reset();
        send_window(8'd50, 8'hCE);
        step();
        for (int w = 0; w < 3; w++) begin
            send_window(8'h00, 8'h00);
            step();
        end
        request_and_check("decay3", 8'd94);
        for (int w = 0; w < 46; w++) begin
            send_window(8'h00, 8'h00);
            step();
        end
        request_and_check("decay49", 8'd2);
        for (int w = 0; w < 14; w++) begin
            send_window(8'h00, 8'h00);
            step();
        end
        request_and_check("decay_floor", 8'd0);

        // Request in the update cycle sees the new level
        do_reset();
        send_window(8'd50, 8'hCE);
        request_and_check("race_update", 8'd100);

        // Clip sample and request together
        do_reset();
        for (int i = 0; i < 3; i++) applyStimulus(8'h7F);
        checkOutput("clip3", 16'(clip_count), 16'd3);
        sample_in    = 8'h80;
        sample_valid = 1'b1;
        dsp_ctrl     = 1'b1;
        step();
        sample_valid = 1'b0;
        dsp_ctrl     = 1'b0;
        checkOutput("clip_race", 16'(clip_count), 16'd1);
        checkOutput("clip_race_ready", 16'(dsp_ready), 16'd1);
        step();

        // Sample arriving during the update seeds the next window
        do_reset();
        send_window(8'd20, 8'd20);
        applyStimulus(8'h7F);
        for (int i = 0; i < 15; i++) applyStimulus(8'd100);
        step();
        request_and_check("seed", 8'd202);

        // Handshake: held-high gives one pulse, toggling gives one per edge
        do_reset();
        send_window(8'd50, 8'hCE);
        step();
        pulses   = 0;
        dsp_ctrl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dsp_ready) pulses++;
        end
        checkOutput("hold_pulses", 16'(pulses), 16'd1);
        checkOutput("hold_out", 16'(dsp_out), 16'd100);
        dsp_ctrl = 1'b0;
        step();
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            dsp_ctrl = 1'b1;
            for (int j = 0; j < 2; j++) begin
                step();
                if (dsp_ready) pulses++;
                checkOutput("toggle_out", 16'(dsp_out), 16'd100);
            end
            dsp_ctrl = 1'b0;
            for (int j = 0; j < 2; j++) begin
                step();
                if (dsp_ready) pulses++;
            end
        end
        checkOutput("toggle_pulses", 16'(pulses), 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
